regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Write-side companion to the integer register file: merges results from three producers (ALU, load unit, mul/div unit) into the single register-file write port (rd, rd_data).
- Holds a per-register busy scoreboard so decode can stall on pending destinations.
- Sits between the execute/memory stages and the register file write port.
- Output is registered: one cycle from accept to write-port drive.

Parameters:
- XLEN, 32, data width of results and write port.
- NREG_W, 5, register index width; 2**NREG_W architectural registers.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_alu_valid  in  1  ALU result present. No backpressure: always accepted.
- i_alu_rd  in  NREG_W  ALU destination
- i_alu_data  in  XLEN  ALU result
- i_ld_valid  in  1  load result present
- o_ld_ready  out  1  load result accepted this cycle
- i_ld_rd  in  NREG_W  load destination
- i_ld_data  in  XLEN  load result
- i_md_valid  in  1  mul/div result present
- o_md_ready  out  1  mul/div result accepted this cycle
- i_md_rd  in  NREG_W  mul/div destination
- i_md_data  in  XLEN  mul/div result
- i_issue_valid  in  1  instruction with destination issued
- i_issue_rd  in  NREG_W  destination to mark busy
- i_q_rs1  in  NREG_W  scoreboard query 1
- i_q_rs2  in  NREG_W  scoreboard query 2
- o_rs1_busy  out  1  i_q_rs1 pending (combinational)
- o_rs2_busy  out  1  i_q_rs2 pending (combinational)
- o_rd  out  NREG_W  register file write index; 0 means no write
- o_rd_data  out  XLEN  register file write data
- o_wb_valid  out  1  o_rd/o_rd_data carry a write this cycle

Behaviour:
- Reset (async): o_rd=0, o_rd_data=0, o_wb_valid=0, all busy bits=0, round-robin pointer=load.
- Transfer rule: a source transfers when valid&&ready. Load and mul/div must hold valid, rd and data stable until ready. Ready is combinational from the valids and the arbiter state.
- Arbitration, one grant per cycle:
  - ALU has absolute priority. If i_alu_valid=1, then o_ld_ready=0 and o_md_ready=0.
  - Otherwise the load vs mul/div choice is set by the arbiter (see Optional Feature).
  - A ready is asserted only to a requester with valid=1.
- Output register: a source accepted in cycle N drives o_rd, o_rd_data and o_wb_valid=1 in cycle N+1.
- If nothing is accepted, the next cycle has o_rd=0, o_rd_data=0 and o_wb_valid=0. o_rd must never hold a stale nonzero index, because the register file writes whenever rd>0.
- Destination x0: accepted normally and handshake completes, but the output is o_rd=0 and o_wb_valid=0. The data is discarded.
- Scoreboard:
  - busy[r] is set at the clock edge where i_issue_valid=1 and i_issue_rd=r, for r≠0.
  - busy[r] is cleared at the edge where a result with rd=r is accepted into the output register. This lets a reader in N+1 see busy=0 while the register file's same-cycle bypass supplies the data.
  - Simultaneous set and clear of the same r: set wins, busy stays 1.
  - busy[0] is hardwired 0.
  - o_rsX_busy = busy[i_q_rsX], pure combinational. The query does not see same-cycle issue or clear.
- Reset mid-operation: in-flight output is dropped (o_rd=0 immediately) and the scoreboard is cleared. Producers that are still valid are re-arbitrated after reset deasserts.

Optional Feature:
- Macro WB_RR_ARB_EN.
- Defined:
  - Round-robin between load and mul/div when both are valid and the ALU is idle.
  - The pointer flips to the other source after each load or mul/div grant.
  - The pointer is not changed by ALU grants or idle cycles.
- Undefined:
  - Fixed priority, load over mul/div. No pointer state.
  - Mul/div may starve under continuous load traffic.

Test Plan:
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF in cycle 0 → cycle 1: o_rd=5, o_rd_data=0xDEADBEEF, o_wb_valid=1; cycle 2: o_rd=0, o_wb_valid=0.
- ALU blocks others: alu(rd=3), ld(rd=4), md(rd=6) all valid in cycle 0 → o_ld_ready=0, o_md_ready=0 in cycle 0; ALU write x3 appears in cycle 1; ld/md are served only from cycle 1 onward once alu_valid drops.
- Arbitration, ld(rd=7) and md(rd=8) held valid for 4 cycles:
  - WB_RR_ARB_EN defined → grants alternate ld, md.
  - Undefined → ld is granted every cycle; md stays ready=0 until ld_valid drops.
- x0 drop: ld_valid=1, rd=0, data=0x1234 → o_ld_ready=1 and the handshake completes; the next cycle has o_rd=0, o_wb_valid=0.
- Scoreboard:
  - Issue rd=9 in cycle 0 → o_rs1_busy=1 for q_rs1=9 from cycle 1.
  - md result rd=9 accepted in cycle 3 → busy=0 in cycle 4, with o_rd=9 in the same cycle 4.
  - Issue rd=9 and accept rd=9 in the same cycle → busy stays 1.
- Async reset: assert i_reset mid-cycle while o_rd=12 → o_rd=0, o_wb_valid=0 and all busy=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/regfile_writeback.sv
// Register-file write-back merge: ALU / load / mul-div results into one registered write port,
// plus a per-register busy scoreboard. Define WB_RR_ARB_EN for round-robin load vs mul/div arbitration.
module regfile_writeback #(
  parameter int XLEN   = 32,
  parameter int NREG_W = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_alu_valid,
  input  logic [NREG_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]   i_alu_data,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [NREG_W-1:0] i_ld_rd,
  input  logic [XLEN-1:0]   i_ld_data,
  input  logic              i_md_valid,
  output logic              o_md_ready,
  input  logic [NREG_W-1:0] i_md_rd,
  input  logic [XLEN-1:0]   i_md_data,
  input  logic              i_issue_valid,
  input  logic [NREG_W-1:0] i_issue_rd,
  input  logic [NREG_W-1:0] i_q_rs1,
  input  logic [NREG_W-1:0] i_q_rs2,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy,
  output logic [NREG_W-1:0] o_rd,
  output logic [XLEN-1:0]   o_rd_data,
  output logic              o_wb_valid
);

  localparam int NREG = 1 << NREG_W;

  // Handshake: a source transfers on a cycle where valid && ready. Load and mul/div keep
  // valid, rd and data stable until ready; ready depends only on the valids and arbiter state,
  // is raised only to a valid requester, and at most one source is granted per cycle.
  logic              ld_take, md_take, any_take;
  logic [NREG_W-1:0] win_rd;
  logic [XLEN-1:0]   win_data;
  logic [NREG-1:0]   busy, busy_nxt;

`ifdef WB_RR_ARB_EN
  logic rr_md_first;  // 0: load preferred on a tie, 1: mul/div preferred

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)      rr_md_first <= 1'b0;
    else if (ld_take) rr_md_first <= 1'b1;
    else if (md_take) rr_md_first <= 1'b0;
  end

  always_comb begin
    o_ld_ready = 1'b0;
    o_md_ready = 1'b0;
    if (!i_alu_valid) begin
      if (i_ld_valid && i_md_valid) begin
        o_ld_ready = !rr_md_first;
        o_md_ready = rr_md_first;
      end else begin
        o_ld_ready = i_ld_valid;
        o_md_ready = i_md_valid;
      end
    end
  end
`else
  always_comb begin
    o_ld_ready = 1'b0;
    o_md_ready = 1'b0;
    if (!i_alu_valid) begin
      o_ld_ready = i_ld_valid;
      o_md_ready = i_md_valid && !i_ld_valid;
    end
  end
`endif

  assign ld_take  = i_ld_valid && o_ld_ready;
  assign md_take  = i_md_valid && o_md_ready;
  assign any_take = i_alu_valid || ld_take || md_take;

  always_comb begin
    win_rd   = '0;
    win_data = '0;
    if (i_alu_valid) begin
      win_rd   = i_alu_rd;
      win_data = i_alu_data;
    end else if (ld_take) begin
      win_rd   = i_ld_rd;
      win_data = i_ld_data;
    end else if (md_take) begin
      win_rd   = i_md_rd;
      win_data = i_md_data;
    end
  end

  // x0 results complete the handshake but never reach the write port.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rd       <= '0;
      o_rd_data  <= '0;
      o_wb_valid <= 1'b0;
    end else if (any_take && (win_rd != '0)) begin
      o_rd       <= win_rd;
      o_rd_data  <= win_data;
      o_wb_valid <= 1'b1;
    end else begin
      o_rd       <= '0;
      o_rd_data  <= '0;
      o_wb_valid <= 1'b0;
    end
  end

  // Clear on accept, then set on issue, so a same-edge issue of the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (any_take) busy_nxt[win_rd] = 1'b0;
    if (i_issue_valid) busy_nxt[i_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) busy <= '0;
    else         busy <= busy_nxt;
  end

  assign o_rs1_busy = busy[i_q_rs1];
  assign o_rs2_busy = busy[i_q_rs2];

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus randomized traffic
// checked against a transaction-level model (grant choice, busy array, expected write).
module tb_regfile_writeback;
  localparam int XLEN   = 32;
  localparam int NREG_W = 5;
  localparam int NREG   = 32;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_alu_valid;
  logic [NREG_W-1:0] i_alu_rd;
  logic [XLEN-1:0]   i_alu_data;
  logic              i_ld_valid;
  logic              o_ld_ready;
  logic [NREG_W-1:0] i_ld_rd;
  logic [XLEN-1:0]   i_ld_data;
  logic              i_md_valid;
  logic              o_md_ready;
  logic [NREG_W-1:0] i_md_rd;
  logic [XLEN-1:0]   i_md_data;
  logic              i_issue_valid;
  logic [NREG_W-1:0] i_issue_rd;
  logic [NREG_W-1:0] i_q_rs1;
  logic [NREG_W-1:0] i_q_rs2;
  logic              o_rs1_busy;
  logic              o_rs2_busy;
  logic [NREG_W-1:0] o_rd;
  logic [XLEN-1:0]   o_rd_data;
  logic              o_wb_valid;

  regfile_writeback #(.XLEN(XLEN), .NREG_W(NREG_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
    .i_md_valid(i_md_valid), .o_md_ready(o_md_ready), .i_md_rd(i_md_rd), .i_md_data(i_md_data),
    .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
    .i_q_rs1(i_q_rs1), .i_q_rs2(i_q_rs2), .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
    .o_rd(o_rd), .o_rd_data(o_rd_data), .o_wb_valid(o_wb_valid)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic              busy_m[NREG];
  logic [NREG_W-1:0] exp_rd;
  logic [XLEN-1:0]   exp_data;
  logic              exp_valid;
  int                last_grant;  // 0 none, 1 alu, 2 load, 3 mul/div
`ifdef WB_RR_ARB_EN
  bit                pref_md;
`endif

  function automatic int grant_of();
    if (i_alu_valid) return 1;
    if (i_ld_valid && i_md_valid) begin
`ifdef WB_RR_ARB_EN
      return pref_md ? 3 : 2;
`else
      return 2;
`endif
    end
    if (i_ld_valid) return 2;
    if (i_md_valid) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) busy_m[r] = 1'b0;
    exp_rd = '0; exp_data = '0; exp_valid = 1'b0; last_grant = 0;
`ifdef WB_RR_ARB_EN
    pref_md = 1'b0;
`endif
  endtask

  task automatic idle_inputs();
    i_alu_valid = 0; i_alu_rd = '0; i_alu_data = '0;
    i_ld_valid = 0;  i_ld_rd = '0;  i_ld_data = '0;
    i_md_valid = 0;  i_md_rd = '0;  i_md_data = '0;
    i_issue_valid = 0; i_issue_rd = '0;
  endtask

  // Advance one clock edge and update the model; returns 1 ns after the edge.
  task automatic tick();
    int g;
    logic [NREG_W-1:0] rd;
    logic [XLEN-1:0]   d;
    g = grant_of();
    rd = '0; d = '0;
    if (g == 1) begin rd = i_alu_rd; d = i_alu_data; end
    else if (g == 2) begin rd = i_ld_rd; d = i_ld_data; end
    else if (g == 3) begin rd = i_md_rd; d = i_md_data; end
    @(posedge i_clk);
    last_grant = g;
    if (g != 0) busy_m[rd] = 1'b0;
    if (i_issue_valid) busy_m[i_issue_rd] = 1'b1;
    busy_m[0] = 1'b0;
`ifdef WB_RR_ARB_EN
    if (g == 2) pref_md = 1'b1;
    else if (g == 3) pref_md = 1'b0;
`endif
    exp_valid = (g != 0) && (rd != '0);
    exp_rd    = exp_valid ? rd : '0;
    exp_data  = exp_valid ? d : '0;
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    idle_inputs();
    i_q_rs1 = '0; i_q_rs2 = '0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (o_rd !== '0 || o_rd_data !== '0 || o_wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: rd=%0d data=%h v=%b want 0/0/0", o_rd, o_rd_data, o_wb_valid);
    end
    for (int r = 0; r < NREG; r++) begin
      i_q_rs1 = NREG_W'(r); i_q_rs2 = NREG_W'(NREG - 1 - r);
      #1;
      checks++;
      if (o_rs1_busy !== 1'b0 || o_rs2_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy r=%0d: got %b%b want 00", r, o_rs1_busy, o_rs2_busy);
      end
    end
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic test_alu_only();
    @(negedge i_clk);
    i_alu_valid = 1; i_alu_rd = 5; i_alu_data = 32'hDEADBEEF;
    tick();
    checks++;
    if (o_rd !== 5'd5 || o_rd_data !== 32'hDEADBEEF || o_wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL alu_write: rd=%0d data=%h v=%b want 5/deadbeef/1", o_rd, o_rd_data, o_wb_valid);
    end
    @(negedge i_clk);
    idle_inputs();
    tick();
    checks++;
    if (o_rd !== '0 || o_wb_valid !== 1'b0 || o_rd_data !== '0) begin
      errors++;
      $display("FAIL alu_idle: rd=%0d v=%b want 0/0", o_rd, o_wb_valid);
    end
  endtask

  task automatic test_alu_blocks();
    int served;
    @(negedge i_clk);
    i_alu_valid = 1; i_alu_rd = 3; i_alu_data = 32'h3333;
    i_ld_valid = 1;  i_ld_rd = 4;  i_ld_data = 32'h4444;
    i_md_valid = 1;  i_md_rd = 6;  i_md_data = 32'h6666;
    #1;
    checks++;
    if (o_ld_ready !== 1'b0 || o_md_ready !== 1'b0) begin
      errors++;
      $display("FAIL alu_blocks_ready: ld=%b md=%b want 0 0", o_ld_ready, o_md_ready);
    end
    tick();
    checks++;
    if (o_rd !== 5'd3 || o_rd_data !== 32'h3333 || o_wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL alu_blocks_write: rd=%0d data=%h want 3/3333", o_rd, o_rd_data);
    end
    @(negedge i_clk);
    i_alu_valid = 0;
    served = 0;
    for (int c = 0; c < 6 && (i_ld_valid || i_md_valid); c++) begin
      #1;
      checks++;
      if (o_ld_ready !== (grant_of() == 2) || o_md_ready !== (grant_of() == 3)) begin
        errors++;
        $display("FAIL drain_ready: ld=%b md=%b want %b %b", o_ld_ready, o_md_ready,
                 grant_of() == 2, grant_of() == 3);
      end
      tick();
      checks++;
      if (o_rd !== exp_rd || o_rd_data !== exp_data) begin
        errors++;
        $display("FAIL drain_write: rd=%0d data=%h want %0d/%h", o_rd, o_rd_data, exp_rd, exp_data);
      end
      @(negedge i_clk);
      if (last_grant == 2) begin i_ld_valid = 0; served++; end
      if (last_grant == 3) begin i_md_valid = 0; served++; end
    end
    checks++;
    if (served != 2) begin
      errors++;
      $display("FAIL drain_timeout: served %0d want 2", served);
    end
    idle_inputs();
  endtask

  task automatic test_arbitration();
    @(negedge i_clk);
    i_ld_valid = 1; i_ld_rd = 7; i_ld_data = 32'h7777_0000;
    i_md_valid = 1; i_md_rd = 8; i_md_data = 32'h8888_0000;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
`ifdef WB_RR_ARB_EN
      if (o_ld_ready !== (grant_of() == 2) || o_md_ready !== (grant_of() == 3)
          || (c > 0 && (o_ld_ready === (last_grant == 2)))) begin
`else
      if (o_ld_ready !== 1'b1 || o_md_ready !== 1'b0) begin
`endif
        errors++;
        $display("FAIL arb_ready c=%0d: ld=%b md=%b", c, o_ld_ready, o_md_ready);
      end
      tick();
      checks++;
      if (o_rd !== exp_rd || o_rd_data !== exp_data || o_wb_valid !== exp_valid) begin
        errors++;
        $display("FAIL arb_write c=%0d: rd=%0d want %0d", c, o_rd, exp_rd);
      end
      @(negedge i_clk);
      i_ld_data = i_ld_data + 1; i_md_data = i_md_data + 1;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0_drop();
    @(negedge i_clk);
    i_ld_valid = 1; i_ld_rd = 0; i_ld_data = 32'h1234;
    #1;
    checks++;
    if (o_ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready: got %b want 1", o_ld_ready);
    end
    tick();
    checks++;
    if (o_rd !== '0 || o_wb_valid !== 1'b0 || o_rd_data !== '0) begin
      errors++;
      $display("FAIL x0_write: rd=%0d v=%b data=%h want 0/0/0", o_rd, o_wb_valid, o_rd_data);
    end
    @(negedge i_clk);
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    @(negedge i_clk);
    i_issue_valid = 1; i_issue_rd = 9; i_q_rs1 = 9; i_q_rs2 = 0;
    #1;
    checks++;
    if (o_rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL sb_no_sameCycle: got %b want 0", o_rs1_busy);
    end
    tick();
    checks++;
    if (o_rs1_busy !== 1'b1 || o_rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL sb_set: rs1=%b rs2=%b want 1 0", o_rs1_busy, o_rs2_busy);
    end
    @(negedge i_clk);
    idle_inputs();
    tick();
    @(negedge i_clk);
    i_md_valid = 1; i_md_rd = 9; i_md_data = 32'h9999_9999;
    tick();
    checks++;
    if (o_rs1_busy !== 1'b0 || o_rd !== 5'd9 || o_rd_data !== 32'h9999_9999) begin
      errors++;
      $display("FAIL sb_clear: busy=%b rd=%0d want 0/9", o_rs1_busy, o_rd);
    end
    @(negedge i_clk);
    idle_inputs();
    i_issue_valid = 1; i_issue_rd = 9;
    i_alu_valid = 1; i_alu_rd = 9; i_alu_data = 32'h0909;
    tick();
    checks++;
    if (o_rs1_busy !== 1'b1 || o_rd !== 5'd9) begin
      errors++;
      $display("FAIL sb_set_wins: busy=%b rd=%0d want 1/9", o_rs1_busy, o_rd);
    end
    @(negedge i_clk);
    idle_inputs();
    i_alu_valid = 1; i_alu_rd = 9; i_alu_data = 32'h1;
    tick();
    checks++;
    if (o_rs1_busy !== busy_m[9]) begin
      errors++;
      $display("FAIL sb_final_clear: got %b want %b", o_rs1_busy, busy_m[9]);
    end
    @(negedge i_clk);
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge i_clk);
      i_alu_valid = ($urandom_range(0, 3) == 0);
      i_alu_rd = NREG_W'($urandom_range(0, NREG - 1));
      i_alu_data = $urandom;
      if (!(i_ld_valid && last_grant != 2)) begin
        i_ld_valid = ($urandom_range(0, 1) == 1);
        i_ld_rd = NREG_W'($urandom_range(0, NREG - 1));
        i_ld_data = $urandom;
      end
      if (!(i_md_valid && last_grant != 3)) begin
        i_md_valid = ($urandom_range(0, 1) == 1);
        i_md_rd = NREG_W'($urandom_range(0, NREG - 1));
        i_md_data = $urandom;
      end
      i_issue_valid = ($urandom_range(0, 1) == 1);
      i_issue_rd = NREG_W'($urandom_range(0, NREG - 1));
      i_q_rs1 = NREG_W'($urandom_range(0, NREG - 1));
      i_q_rs2 = NREG_W'($urandom_range(0, NREG - 1));
      #1;
      checks++;
      if (o_ld_ready !== (grant_of() == 2) || o_md_ready !== (grant_of() == 3)
          || o_rs1_busy !== busy_m[i_q_rs1] || o_rs2_busy !== busy_m[i_q_rs2]) begin
        errors++;
        $display("FAIL rand_comb c=%0d: ld=%b md=%b b1=%b b2=%b want %b %b %b %b", c,
                 o_ld_ready, o_md_ready, o_rs1_busy, o_rs2_busy, grant_of() == 2,
                 grant_of() == 3, busy_m[i_q_rs1], busy_m[i_q_rs2]);
      end
      tick();
      checks++;
      if (o_rd !== exp_rd || o_rd_data !== exp_data || o_wb_valid !== exp_valid) begin
        errors++;
        $display("FAIL rand_write c=%0d: rd=%0d data=%h v=%b want %0d/%h/%b", c,
                 o_rd, o_rd_data, o_wb_valid, exp_rd, exp_data, exp_valid);
      end
    end
    @(negedge i_clk);
    idle_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    @(negedge i_clk);
    i_alu_valid = 1; i_alu_rd = 12; i_alu_data = 32'hC0FFEE12;
    i_issue_valid = 1; i_issue_rd = 20; i_q_rs1 = 20; i_q_rs2 = 12;
    tick();
    checks++;
    if (o_rd !== 5'd12 || o_rs1_busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup: rd=%0d busy=%b want 12/1", o_rd, o_rs1_busy);
    end
    idle_inputs();
    i_ld_valid = 1; i_ld_rd = 11; i_ld_data = 32'hB0B0_0011;
    #2;
    i_reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (o_rd !== '0 || o_wb_valid !== 1'b0 || o_rd_data !== '0 || o_rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: rd=%0d v=%b busy=%b want 0/0/0", o_rd, o_wb_valid, o_rs1_busy);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_rearb_ready: got %b want 1", o_ld_ready);
    end
    tick();
    checks++;
    if (o_rd !== 5'd11 || o_rd_data !== 32'hB0B0_0011) begin
      errors++;
      $display("FAIL areset_rearb_write: rd=%0d data=%h want 11/b0b00011", o_rd, o_rd_data);
    end
    @(negedge i_clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_alu_blocks();
    test_arbitration();
    test_x0_drop();
    test_scoreboard();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
